// File: rtl/udma_hyper_ch_sched.sv
// ---------------------------------------------------------------------------
// udma_hyper_ch_sched
//
// Shares the single HyperBus PHY/controller datapath between NB_CH uDMA
// HyperBus channels. Requests are arbitrated round-robin; one owner holds
// the PHY from grant until the end of its recovery gap. Each transaction is
// guarded by a CS-max style watchdog, and a read/write recovery gap is
// enforced before the next grant.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_ch_en_i           per-channel enable (disabled channels never granted)
//   cfg_t_cs_max_i        watchdog limit in cycles (0 = watchdog off)
//   cfg_t_rw_recovery_i   idle cycles between transactions (0 behaves as 1)
//   req_i                 level request per channel
//   gnt_o                 one-hot single-cycle grant pulse
//   busy_vec_o            one-hot current PHY owner, 0 when idle
//   err_o                 single-cycle pulse to the owner on watchdog abort
//   phy_ready_i           PHY can accept a new start
//   phy_start_o           single-cycle start pulse to the PHY
//   phy_ch_o              owner index (holds its last value while idle)
//   phy_done_i            PHY transaction complete pulse
//   phy_abort_o           single-cycle abort pulse to the PHY
// ---------------------------------------------------------------------------
module udma_hyper_ch_sched #(
  parameter int NB_CH     = 4,
  parameter int CNT_WIDTH = 32,
  localparam int CH_W     = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NB_CH-1:0]     cfg_ch_en_i,
  input  logic [CNT_WIDTH-1:0] cfg_t_cs_max_i,
  input  logic [CNT_WIDTH-1:0] cfg_t_rw_recovery_i,
  input  logic [NB_CH-1:0]     req_i,
  output logic [NB_CH-1:0]     gnt_o,
  output logic [NB_CH-1:0]     busy_vec_o,
  output logic [NB_CH-1:0]     err_o,
  input  logic                 phy_ready_i,
  output logic                 phy_start_o,
  output logic [CH_W-1:0]      phy_ch_o,
  input  logic                 phy_done_i,
  output logic                 phy_abort_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0]      LAST_RST = CH_W'(NB_CH - 1);

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [NB_CH-1:0] to_onehot(input logic [CH_W-1:0] idx);
    logic [NB_CH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [1:0]           state_q;
  logic [CH_W-1:0]      owner_q;
  logic [CH_W-1:0]      last_q;
  logic [CNT_WIDTH-1:0] wd_cnt_q;
  logic [CNT_WIDTH-1:0] rec_cnt_q;
  logic [CNT_WIDTH-1:0] cs_max_q;
  logic [CNT_WIDTH-1:0] rec_q;

  logic [NB_CH-1:0] elig;
  logic [CH_W-1:0]  rr_idx;
  logic [CH_W-1:0]  sel;
  logic             sel_vld;
  logic             wd_hit;
  logic             abort;
  logic [NB_CH-1:0] owner_oh;

  assign elig = req_i & cfg_ch_en_i;

  // Round-robin pick: walk downward from the farthest candidate so the
  // nearest eligible channel after last_q is the one left in sel.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    rr_idx  = '0;
    for (int i = NB_CH; i >= 1; i--) begin
      rr_idx = CH_W'((int'(last_q) + i) % NB_CH);
      if (elig[rr_idx]) begin
        sel     = rr_idx;
        sel_vld = 1'b1;
      end
    end
  end

  // The counter is 0 on the first ACTIVE cycle, so cs_max-1 marks the
  // cs_max-th ACTIVE cycle. A simultaneous done suppresses the abort.
  assign wd_hit = (cs_max_q != '0) && (wd_cnt_q == cs_max_q - CNT_ONE);
  assign abort  = (state_q == ST_ACTIVE) && wd_hit && !phy_done_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      last_q    <= LAST_RST;
      wd_cnt_q  <= '0;
      rec_cnt_q <= '0;
      cs_max_q  <= '0;
      rec_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_vld && phy_ready_i) begin
            owner_q <= sel;
            last_q  <= sel;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          // Shadow the timing config so later changes leave this transaction alone.
          cs_max_q <= cfg_t_cs_max_i;
          rec_q    <= cfg_t_rw_recovery_i;
          wd_cnt_q <= '0;
          state_q  <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          wd_cnt_q <= sat_inc(wd_cnt_q);
          if (phy_done_i || wd_hit) begin
            rec_cnt_q <= CNT_ONE;
            state_q   <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          // Counting from 1 makes a zero recovery setting last one cycle.
          if (rec_cnt_q >= rec_q) begin
            state_q <= ST_IDLE;
          end else begin
            rec_cnt_q <= sat_inc(rec_cnt_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign owner_oh    = to_onehot(owner_q);
  assign gnt_o       = (state_q == ST_START) ? owner_oh : '0;
  assign phy_start_o = (state_q == ST_START);
  assign busy_vec_o  = (state_q != ST_IDLE) ? owner_oh : '0;
  assign phy_ch_o    = owner_q;
  assign phy_abort_o = abort;
  assign err_o       = abort ? owner_oh : '0;

endmodule

// File: tb/tb_udma_hyper_ch_sched.sv
// ---------------------------------------------------------------------------
// Testbench for udma_hyper_ch_sched. Inputs are driven on the falling edge;
// expected outputs come from a timestamp-based transaction model (grant
// cycle, end cycle, latched watchdog/recovery values) evaluated per cycle.
// ---------------------------------------------------------------------------
module tb_udma_hyper_ch_sched;

  localparam int NB_CH     = 4;
  localparam int CNT_WIDTH = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [NB_CH-1:0]     cfg_ch_en_i = '0;
  logic [CNT_WIDTH-1:0] cfg_t_cs_max_i = '0;
  logic [CNT_WIDTH-1:0] cfg_t_rw_recovery_i = '0;
  logic [NB_CH-1:0]     req_i = '0;
  logic [NB_CH-1:0]     gnt_o;
  logic [NB_CH-1:0]     busy_vec_o;
  logic [NB_CH-1:0]     err_o;
  logic                 phy_ready_i = 1'b0;
  logic                 phy_start_o;
  logic [1:0]           phy_ch_o;
  logic                 phy_done_i = 1'b0;
  logic                 phy_abort_o;

  always #5 clk_i = ~clk_i;

  udma_hyper_ch_sched #(.NB_CH(NB_CH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .cfg_ch_en_i         (cfg_ch_en_i),
    .cfg_t_cs_max_i      (cfg_t_cs_max_i),
    .cfg_t_rw_recovery_i (cfg_t_rw_recovery_i),
    .req_i               (req_i),
    .gnt_o               (gnt_o),
    .busy_vec_o          (busy_vec_o),
    .err_o               (err_o),
    .phy_ready_i         (phy_ready_i),
    .phy_start_o         (phy_start_o),
    .phy_ch_o            (phy_ch_o),
    .phy_done_i          (phy_done_i),
    .phy_abort_o         (phy_abort_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: a transaction is described by the cycle of its grant
  // (m_gcyc), the ACTIVE cycle on which it ended (m_end, -1 while running)
  // and the config values captured on the grant cycle.
  int t;
  bit have_tx;
  int m_owner, m_last, m_ch, m_gcyc, m_end, m_cs, m_rec;
  int n_grants, n_aborts;

  function automatic void model_reset();
    t       = 0;
    have_tx = 1'b0;
    m_owner = 0;
    m_last  = NB_CH - 1;
    m_ch    = 0;
    m_gcyc  = 0;
    m_end   = -1;
    m_cs    = 0;
    m_rec   = 1;
  endfunction

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input logic [3:0] req, input logic [3:0] en, input logic rdy,
                      input logic done, input int cs, input int rec);
    int         ph;
    int         k;
    bit         wd;
    logic [3:0] e_oh;
    logic [3:0] elig;
    @(negedge clk_i);
    req_i               = req;
    cfg_ch_en_i         = en;
    phy_ready_i         = rdy;
    phy_done_i          = done;
    cfg_t_cs_max_i      = 32'(cs);
    cfg_t_rw_recovery_i = 32'(rec);
    #1;
    // 0 idle, 1 grant cycle, 2 transfer running, 3 recovery gap
    if (!have_tx)                  ph = 0;
    else if (t == m_gcyc)          ph = 1;
    else if (m_end < 0)            ph = 2;
    else if (t <= m_end + m_rec)   ph = 3;
    else begin have_tx = 1'b0;     ph = 0; end

    e_oh = '0;
    if (ph != 0) e_oh[m_owner] = 1'b1;
    k  = t - m_gcyc;
    wd = (ph == 2) && (m_cs != 0) && (k == m_cs) && !done;

    check("gnt",   gnt_o,       (ph == 1) ? e_oh : 4'b0);
    check("start", phy_start_o, (ph == 1) ? 1 : 0);
    check("busy",  busy_vec_o,  e_oh);
    check("ch",    phy_ch_o,    m_ch);
    check("abort", phy_abort_o, wd ? 1 : 0);
    check("err",   err_o,       wd ? e_oh : 4'b0);

    case (ph)
      1: begin
        m_cs  = cs;
        m_rec = (rec == 0) ? 1 : rec;
      end
      2: begin
        if (done || wd) m_end = t;
        if (wd) n_aborts++;
      end
      0: begin
        elig = req & en;
        if (elig != 0 && rdy) begin
          for (int i = NB_CH; i >= 1; i--) begin
            if (elig[(m_last + i) % NB_CH]) m_owner = (m_last + i) % NB_CH;
          end
          m_last  = m_owner;
          m_ch    = m_owner;
          have_tx = 1'b1;
          m_gcyc  = t + 1;
          m_end   = -1;
          n_grants++;
        end
      end
      default: ;
    endcase
    t++;
  endtask

  initial begin
    int cs_cur;
    int rec_cur;
    logic [3:0] en_cur;
    n_grants = 0;
    n_aborts = 0;
    model_reset();

    // Outputs while reset is held.
    repeat (2) @(negedge clk_i);
    check("rst_gnt",  gnt_o, 0);
    check("rst_busy", busy_vec_o, 0);
    check("rst_ch",   phy_ch_o, 0);
    check("rst_start", phy_start_o, 0);
    rst_i = 1'b0;

    // Grant channel 2, let it run a few ACTIVE cycles, then reset asynchronously.
    step(4'b0100, 4'hF, 1'b1, 1'b0, 0, 2);
    step(4'b0000, 4'hF, 1'b1, 1'b0, 0, 2);
    step(4'b0000, 4'hF, 1'b1, 1'b0, 0, 2);
    step(4'b0000, 4'hF, 1'b1, 1'b0, 0, 2);
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy",  busy_vec_o, 0);
    check("arst_ch",    phy_ch_o, 0);
    check("arst_abort", phy_abort_o, 0);
    check("arst_gnt",   gnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();

    // After reset channel 0 wins first arbitration.
    step(4'b0101, 4'hF, 1'b1, 1'b0, 0, 2);
    step(4'b0000, 4'hF, 1'b1, 1'b0, 0, 2);
    check("gnt_after_rst", gnt_o, 4'b0001);
    step(4'b0000, 4'hF, 1'b1, 1'b1, 0, 2);

    // Randomized traffic with occasional config/enable changes.
    cs_cur  = 5;
    rec_cur = 2;
    en_cur  = 4'hF;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) cs_cur  = $urandom_range(0, 12);
      if ($urandom_range(0, 9) == 0) rec_cur = $urandom_range(0, 4);
      if ($urandom_range(0, 19) == 0) en_cur = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      step(4'($urandom), en_cur, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, cs_cur, rec_cur);
    end

    // The random phase must actually have exercised grants and aborts.
    check("saw_grants", (n_grants > 50) ? 1 : 0, 1);
    check("saw_aborts", (n_aborts > 5) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/udma_hyper_ch_sched.md
# udma_hyper_ch_sched

Transaction scheduler that shares the single HyperBus PHY/controller datapath between NB_CH uDMA HyperBus channels. It arbitrates channel requests round-robin and grants one owner at a time. It enforces a per-transaction watchdog (CS-max style) and the read/write recovery gap between transactions. It publishes the per-channel busy vector consumed by the common register interface for transaction-ID allocation.

## Interface
Parameters:
- NB_CH, 4, number of requesting channels (≥2)
- CNT_WIDTH, 32, width of watchdog and recovery counters and their config inputs

Ports:
- clk_i  in  1  clock; all logic on its rising edge
- rst_i  in  1  asynchronous, active-high reset
- cfg_ch_en_i  in  NB_CH  per-channel enable; a disabled channel is never granted
- cfg_t_cs_max_i  in  CNT_WIDTH  watchdog limit in cycles; 0 disables the watchdog
- cfg_t_rw_recovery_i  in  CNT_WIDTH  idle cycles between transactions
- req_i  in  NB_CH  level request per channel, held until granted
- gnt_o  out  NB_CH  one-hot, one-cycle grant pulse
- busy_vec_o  out  NB_CH  one-hot owner of the PHY, 0 when idle
- err_o  out  NB_CH  one-cycle pulse to the owner on watchdog abort
- phy_ready_i  in  1  PHY idle and able to accept a start
- phy_start_o  out  1  one-cycle start pulse to the PHY
- phy_ch_o  out  $clog2(NB_CH)  current owner index, valid while busy_vec_o≠0
- phy_done_i  in  1  PHY transaction complete (single-cycle pulse)
- phy_abort_o  out  1  one-cycle abort pulse to the PHY

## Operation
- FSM states: IDLE, START, ACTIVE, RECOVER.
- **IDLE**
  - Eligible set = req_i & cfg_ch_en_i.
  - If the set is nonzero and phy_ready_i=1, select the first eligible index searching upward from (last_owner+1) mod NB_CH, wrapping.
  - Register the selection as owner and last_owner, then go to START.
  - last_owner resets to NB_CH-1, so channel 0 wins the first arbitration.
- **START** (exactly 1 cycle)
  - gnt_o[owner]=1 and phy_start_o=1.
  - Latch cfg_t_cs_max_i and cfg_t_rw_recovery_i into shadow registers.
  - Clear the watchdog counter, then go to ACTIVE.
- **ACTIVE**
  - Watchdog counter increments each cycle.
  - phy_done_i=1: go to RECOVER with no error.
  - Else if the shadow cs_max≠0 and the counter equals cs_max−1: phy_abort_o=1 and err_o[owner]=1 for that cycle, then go to RECOVER.
  - If phy_done_i and the watchdog limit occur in the same cycle, done wins and no abort is issued.
  - The counter saturates and does not wrap.
- **RECOVER**
  - Lasts max(shadow recovery,1) cycles, then returns to IDLE.
  - last_owner is kept.
- **busy_vec_o and phy_ch_o**
  - busy_vec_o = one-hot(owner) in START, ACTIVE and RECOVER; 0 in IDLE.
  - phy_ch_o holds owner and keeps its last value while idle.
- **Config and enable changes**
  - Config changes after START do not affect the running transaction.
  - Disabling the owner's channel mid-transaction has no effect on that transaction.
  - A request deasserted before selection is simply not considered.
  - req_i is sampled only in IDLE.
- **Reset** (any time, including mid-transaction)
  - All outputs are 0 and the FSM is in IDLE.
  - Counters and shadows are 0; last_owner=NB_CH-1.
  - No abort is emitted on reset.

## Timing
- Request-to-grant latency is 1 cycle:
  - Eligible req with phy_ready_i at IDLE cycle N gives gnt_o and phy_start_o at cycle N+1.
  - The FSM is in ACTIVE at N+2.
- Watchdog with cs_max=C: the abort pulse occurs at the C-th ACTIVE cycle.
- Done to next grant: phy_done_i in cycle M gives RECOVER for cycles M+1..M+R, IDLE at M+R+1, and the earliest next gnt_o at M+R+2 (R = max(rec,1)).
- gnt_o, phy_start_o, phy_abort_o and err_o are registered single-cycle pulses, never asserted for two consecutive cycles.
- At most one bit of gnt_o, busy_vec_o and err_o is set at any time.

## Test plan
- **Reset values:** assert rst_i mid-ACTIVE with owner 2 → all outputs 0 immediately (async). After release, req_i=4'b0101 with phy_ready_i=1 → gnt_o=4'b0001.
- **Round-robin fairness:** req_i=4'b1111 held, cfg_ch_en_i=4'hF, phy_done_i 3 cycles after each start, recovery=2 → grant order 0,1,2,3,0. Done-to-next-grant spacing is exactly 4 cycles.
- **Enable mask and phy_ready gating:**
  - cfg_ch_en_i=4'b1010, req_i=4'b1111 → only channels 1,3 granted, alternating.
  - Hold phy_ready_i=0 for 5 cycles → no grant until one cycle after phy_ready_i rises.
- **Watchdog abort:** cs_max=10, phy_done_i never asserted → phy_abort_o and err_o[owner] pulse on the 10th ACTIVE cycle, then RECOVER. cs_max=0 → FSM stays in ACTIVE indefinitely.
- **Done/timeout collision:** cs_max=5 with phy_done_i on the 5th ACTIVE cycle → no abort, no err_o, normal RECOVER.
- **Config shadowing:** change recovery from 3 to 20 during ACTIVE → RECOVER lasts 3 cycles. Recovery=0 → RECOVER lasts 1 cycle.
